// File: rtl/calc_operand_seq_v.sv
// rtl/calc_operand_seq_v.sv - nibble-to-operand sequencer and result register around unsigned_calc_v
// Optional macro CALC_WRAP_FLAG_EN enables the below-zero wrap flag on o_wrap.
module calc_operand_seq_v #(
    parameter int HOLD_OPERANDS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_nib_valid,
    input  logic [3:0] i_nib,
    output logic       o_nib_ready,
    output logic [3:0] o_au,
    output logic [3:0] o_bu,
    output logic [3:0] o_cu,
    input  logic [7:0] i_fu,
    output logic [7:0] o_res,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic       o_busy,
    output logic       o_wrap
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_C    = 3'd2,
        S_EVAL = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   res_take;

    // Handshake outputs decode straight from the state register, so i_res_ready never reaches o_nib_ready.
    assign o_nib_ready = (state == S_A) || (state == S_B) || (state == S_C);
    assign o_res_valid = (state == S_OUT);
    assign o_busy      = (state != S_A);
    assign accept      = i_nib_valid & o_nib_ready;
    assign res_take    = o_res_valid & i_res_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_A:     if (accept) state_next = S_B;
            S_B:     if (accept) state_next = S_C;
            S_C:     if (accept) state_next = S_EVAL;
            S_EVAL:  state_next = S_OUT;
            S_OUT:   if (res_take) state_next = S_A;
            default: state_next = S_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_A;
            o_au  <= 4'd0;
            o_bu  <= 4'd0;
            o_cu  <= 4'd0;
            o_res <= 8'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                case (state)
                    S_A:     o_au <= i_nib;
                    S_B:     o_bu <= i_nib;
                    S_C:     o_cu <= i_nib;
                    default: ;
                endcase
            end
            if (state == S_EVAL)
                o_res <= i_fu;
            if (res_take && (HOLD_OPERANDS == 0)) begin
                o_au <= 4'd0;
                o_bu <= 4'd0;
                o_cu <= 4'd0;
            end
        end
    end

`ifdef CALC_WRAP_FLAG_EN
    logic [7:0] pos_sum;
    logic [7:0] neg_sum;

    // 7a + 6c peaks at 195 and 3b at 45, so 8-bit sums never overflow.
    assign pos_sum = 8'd7 * {4'd0, o_au} + 8'd6 * {4'd0, o_cu};
    assign neg_sum = 8'd3 * {4'd0, o_bu};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_wrap <= 1'b0;
        else if (state == S_EVAL)
            o_wrap <= (pos_sum < neg_sum);
    end
`else
    assign o_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_calc_operand_seq_v.sv
// tb/tb_calc_operand_seq_v.sv - directed and random checks of calc_operand_seq_v in both HOLD_OPERANDS modes
module tb_calc_operand_seq_v;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_nib_valid = 1'b0;
    logic [3:0] i_nib = 4'd0;
    logic       i_res_ready = 1'b0;

    logic       ready_h, ready_c, rv_h, rv_c, busy_h, busy_c, wrap_h, wrap_c;
    logic [3:0] au_h, bu_h, cu_h, au_c, bu_c, cu_c;
    logic [7:0] fu_h, fu_c, res_h, res_c;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    // Stand-ins for the combinational unsigned_calc_v, one per DUT.
    assign fu_h = 8'd7 * {4'd0, au_h} - 8'd3 * {4'd0, bu_h} + 8'd6 * {4'd0, cu_h};
    assign fu_c = 8'd7 * {4'd0, au_c} - 8'd3 * {4'd0, bu_c} + 8'd6 * {4'd0, cu_c};

    calc_operand_seq_v #(.HOLD_OPERANDS(1)) dut_h (
        .i_clk(i_clk), .i_rst(i_rst), .i_nib_valid(i_nib_valid), .i_nib(i_nib),
        .o_nib_ready(ready_h), .o_au(au_h), .o_bu(bu_h), .o_cu(cu_h), .i_fu(fu_h),
        .o_res(res_h), .o_res_valid(rv_h), .i_res_ready(i_res_ready),
        .o_busy(busy_h), .o_wrap(wrap_h)
    );

    calc_operand_seq_v #(.HOLD_OPERANDS(0)) dut_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_nib_valid(i_nib_valid), .i_nib(i_nib),
        .o_nib_ready(ready_c), .o_au(au_c), .o_bu(bu_c), .o_cu(cu_c), .i_fu(fu_c),
        .o_res(res_c), .o_res_valid(rv_c), .i_res_ready(i_res_ready),
        .o_busy(busy_c), .o_wrap(wrap_c)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready_h"}, ready_h, 1);
        chk({tag, " ready_c"}, ready_c, 1);
        chk({tag, " busy_h"}, busy_h, 0);
        chk({tag, " busy_c"}, busy_c, 0);
        chk({tag, " rv_h"}, rv_h, 0);
        chk({tag, " rv_c"}, rv_c, 0);
    endtask

    // Reference: f = 7a - 3b + 6c taken modulo 256; wrap means the true value is negative.
    task automatic run_op(input int a, input int b, input int c,
                          input int g0, input int g1, input int g2, input int hold);
        int nib[3];
        int gap[3];
        int v;
        logic [7:0] exp_res;
        logic exp_wrap;
        nib[0] = a; nib[1] = b; nib[2] = c;
        gap[0] = g0; gap[1] = g1; gap[2] = g2;
        v = 7 * a - 3 * b + 6 * c;
        exp_res = 8'(((v % 256) + 256) % 256);
`ifdef CALC_WRAP_FLAG_EN
        exp_wrap = (v < 0);
`else
        exp_wrap = 1'b0;
`endif
        i_res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                i_nib_valid = 1'b0;
                i_nib = 4'($urandom);
                step();
                chk("gap ready", ready_h, 1);
            end
            i_nib_valid = 1'b1;
            i_nib = 4'(nib[k]);
            chk("load ready_h", ready_h, 1);
            chk("load ready_c", ready_c, 1);
            step();
        end
        // Keep valid asserted with junk to prove nothing is taken during EVAL/OUT.
        i_nib = 4'($urandom);
        chk("eval ready", ready_h, 0);
        chk("eval busy", busy_h, 1);
        chk("eval rv", rv_h, 0);
        chk("eval ops_h", {au_h, bu_h, cu_h}, {4'(a), 4'(b), 4'(c)});
        chk("eval ops_c", {au_c, bu_c, cu_c}, {4'(a), 4'(b), 4'(c)});
        i_res_ready = (hold == 0);
        step();
        chk("out rv_h", rv_h, 1);
        chk("out rv_c", rv_c, 1);
        chk("out res_h", res_h, exp_res);
        chk("out res_c", res_c, exp_res);
        chk("out wrap_h", wrap_h, exp_wrap);
        chk("out wrap_c", wrap_c, exp_wrap);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp rv", rv_h, 1);
            chk("bp res", res_h, exp_res);
            chk("bp wrap", wrap_h, exp_wrap);
            chk("bp ready", ready_h, 0);
            chk("bp busy", busy_h, 1);
            chk("bp ops", {au_h, bu_h, cu_h}, {4'(a), 4'(b), 4'(c)});
        end
        i_res_ready = 1'b1;
        i_nib_valid = 1'b0;
        step();
        chk_idle("post");
        chk("post res_h", res_h, exp_res);
        chk("post ops_h", {au_h, bu_h, cu_h}, {4'(a), 4'(b), 4'(c)});
        chk("post ops_c", {au_c, bu_c, cu_c}, 12'd0);
        i_res_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        step();
        step();
        chk_idle("reset");
        chk("reset ops_h", {au_h, bu_h, cu_h}, 12'd0);
        chk("reset res_h", res_h, 0);
        chk("reset wrap_h", wrap_h, 0);
        chk("reset wrap_c", wrap_c, 0);
        i_rst = 1'b0;

        run_op(2, 1, 3, 0, 0, 0, 0);
        run_op(15, 15, 15, 0, 0, 0, 0);
        run_op(0, 15, 0, 0, 0, 0, 0);
        run_op(1, 2, 1, 0, 0, 0, 5);
        run_op(4, 2, 5, 0, 3, 1, 0);

        // Reset after a and b loaded.
        i_nib_valid = 1'b1;
        i_nib = 4'd7;
        step();
        i_nib = 4'd1;
        step();
        chk("mid b", bu_h, 1);
        i_nib_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk_idle("midrst");
        chk("midrst ops_h", {au_h, bu_h}, 8'd0);
        chk("midrst ops_c", {au_c, bu_c}, 8'd0);
        run_op(1, 1, 1, 0, 0, 0, 0);

        // Reset while a result is pending, with the downstream ready: reset wins.
        i_nib_valid = 1'b1;
        i_nib = 4'd3;
        step(); step(); step();
        i_nib_valid = 1'b0;
        step();
        chk("pend rv", rv_h, 1);
        i_rst = 1'b1;
        i_res_ready = 1'b1;
        step();
        i_rst = 1'b0;
        i_res_ready = 1'b0;
        chk_idle("pendrst");
        chk("pendrst res", res_h, 0);
        run_op(9, 4, 2, 1, 0, 2, 1);

        for (int r = 0; r < 20; r++)
            run_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
                   int'($urandom_range(2)), int'($urandom_range(2)), int'($urandom_range(2)),
                   int'($urandom_range(3)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
